// File: rtl/main_memory_responder.sv
// main_memory_responder: byte-wide main-memory responder for a cache's miss-fill
// and write-through traffic. Holds 2^ADDR_W bytes. A read is answered READ_LAT
// cycles after acceptance with a one-cycle validMemData strobe. A write commits
// in one cycle and is acknowledged by a registered writeAck pulse.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   memAddr      byte address from the cache
//   memRead      level read request
//   memWrite     level write request (write-through)
//   memDataIn    write data
//   memDataOut   read data, meaningful while validMemData=1, otherwise held
//   validMemData one-cycle strobe marking valid memDataOut
//   writeAck     one-cycle pulse following each committed write
//   ready        responder is idle and will accept a request
//   protocolErr  sticky: memRead and memWrite seen together while idle
module main_memory_responder #(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned READ_LAT       = 3,
    parameter int unsigned CLEAR_ON_RESET = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] memAddr,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [7:0]        memDataIn,
    output logic [7:0]        memDataOut,
    output logic              validMemData,
    output logic              writeAck,
    output logic              ready,
    output logic              protocolErr
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned ST_W  = 2;

    localparam logic [ST_W-1:0] ST_CLEAR   = 2'd0;
    localparam logic [ST_W-1:0] ST_IDLE    = 2'd1;
    localparam logic [ST_W-1:0] ST_RD_WAIT = 2'd2;
    localparam logic [ST_W-1:0] ST_RD_DATA = 2'd3;

    localparam logic [ST_W-1:0]   RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
    localparam logic [CNT_W-1:0]  LAT_LOAD    = CNT_W'(READ_LAT - 1);
    localparam logic [ADDR_W-1:0] CLR_LAST    = '1;

    logic [7:0] mem [0:DEPTH-1];

    logic [ST_W-1:0]   state_q,    state_d;
    logic [CNT_W-1:0]  lat_cnt_q,  lat_cnt_d;
    logic [ADDR_W-1:0] rd_addr_q,  rd_addr_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [7:0]        mem_data_q, mem_data_d;
    logic              valid_q,    valid_d;
    logic              ack_q,      ack_d;
    logic              ready_q,    ready_d;
    logic              err_q,      err_d;

    // Single array write port shared by the clear sweep and cache writes
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_waddr_c;
    logic [7:0]        mem_wdata_c;

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        rd_addr_d   = rd_addr_q;
        clr_addr_d  = clr_addr_q;
        mem_data_d  = mem_data_q;
        valid_d     = 1'b0;
        ack_d       = 1'b0;
        err_d       = err_q;
        mem_we_c    = 1'b0;
        mem_waddr_c = memAddr;
        mem_wdata_c = memDataIn;

        case (state_q)
            ST_CLEAR: begin
                mem_we_c    = 1'b1;
                mem_waddr_c = clr_addr_q;
                mem_wdata_c = 8'h00;
                if (clr_addr_q == CLR_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_W'(1);
                end
            end
            ST_IDLE: begin
                if (memWrite) begin
                    // Write wins a read/write collision; the read is dropped
                    mem_we_c = 1'b1;
                    ack_d    = 1'b1;
                    if (memRead) begin
                        err_d = 1'b1;
                    end
                end else if (memRead) begin
                    rd_addr_d = memAddr;
                    lat_cnt_d = LAT_LOAD;
                    state_d   = (READ_LAT == 1) ? ST_RD_DATA : ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (!memRead) begin
                    state_d = ST_IDLE;
                end else begin
                    // Counter reaching zero hands over to the data cycle
                    lat_cnt_d = lat_cnt_q - CNT_W'(1);
                    if (lat_cnt_q == CNT_W'(1)) begin
                        state_d = ST_RD_DATA;
                    end
                end
            end
            ST_RD_DATA: begin
                valid_d    = 1'b1;
                mem_data_d = mem[rd_addr_q];
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RESET_STATE;
            lat_cnt_q  <= '0;
            rd_addr_q  <= '0;
            clr_addr_q <= '0;
            mem_data_q <= 8'h00;
            valid_q    <= 1'b0;
            ack_q      <= 1'b0;
            ready_q    <= (CLEAR_ON_RESET == 0);
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            rd_addr_q  <= rd_addr_d;
            clr_addr_q <= clr_addr_d;
            mem_data_q <= mem_data_d;
            valid_q    <= valid_d;
            ack_q      <= ack_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
        end
    end

    // Storage array; contents survive reset unless the clear sweep runs
    always_ff @(posedge clk) begin
        if (mem_we_c && !rst) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    assign memDataOut   = mem_data_q;
    assign validMemData = valid_q;
    assign writeAck     = ack_q;
    assign ready        = ready_q;
    assign protocolErr  = err_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// tb_main_memory_responder: three responder builds driven by directed vectors.
//   inst 0: ADDR_W=16, READ_LAT=3, no clear
//   inst 1: ADDR_W=8,  READ_LAT=1, no clear
//   inst 2: ADDR_W=6,  READ_LAT=2, clear on reset
// A transaction-level reference model predicts every output every cycle; literal
// expectations pin latency, data and cycle counts.
module tb_main_memory_responder;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v  [NI];
    logic        rd_v   [NI];
    logic        wr_v   [NI];
    logic [7:0]  din_v  [NI];
    logic [7:0]  dout_v [NI];
    logic        valid_v[NI];
    logic        ack_v  [NI];
    logic        ready_v[NI];
    logic        err_v  [NI];
    logic [15:0] addr_a;
    logic [7:0]  addr_b;
    logic [5:0]  addr_c;

    int n_checks = 0;
    int n_fail   = 0;

    main_memory_responder #(.ADDR_W(16), .READ_LAT(3), .CLEAR_ON_RESET(0)) u_dut_a (
        .clk(clk), .rst(rst_v[0]), .memAddr(addr_a), .memRead(rd_v[0]), .memWrite(wr_v[0]),
        .memDataIn(din_v[0]), .memDataOut(dout_v[0]), .validMemData(valid_v[0]),
        .writeAck(ack_v[0]), .ready(ready_v[0]), .protocolErr(err_v[0]));

    main_memory_responder #(.ADDR_W(8), .READ_LAT(1), .CLEAR_ON_RESET(0)) u_dut_b (
        .clk(clk), .rst(rst_v[1]), .memAddr(addr_b), .memRead(rd_v[1]), .memWrite(wr_v[1]),
        .memDataIn(din_v[1]), .memDataOut(dout_v[1]), .validMemData(valid_v[1]),
        .writeAck(ack_v[1]), .ready(ready_v[1]), .protocolErr(err_v[1]));

    main_memory_responder #(.ADDR_W(6), .READ_LAT(2), .CLEAR_ON_RESET(1)) u_dut_c (
        .clk(clk), .rst(rst_v[2]), .memAddr(addr_c), .memRead(rd_v[2]), .memWrite(wr_v[2]),
        .memDataIn(din_v[2]), .memDataOut(dout_v[2]), .validMemData(valid_v[2]),
        .writeAck(ack_v[2]), .ready(ready_v[2]), .protocolErr(err_v[2]));

    function automatic int lat_of(input int i);
        return (i == 0) ? 3 : (i == 1) ? 1 : 2;
    endfunction

    function automatic int depth_of(input int i);
        return (i == 0) ? 65536 : (i == 1) ? 256 : 64;
    endfunction

    function automatic bit clr_of(input int i);
        return (i == 2);
    endfunction

    function automatic int get_addr(input int i);
        if (i == 0) return int'(addr_a);
        if (i == 1) return int'(addr_b);
        return int'(addr_c);
    endfunction

    task automatic set_addr(input int i, input logic [15:0] a);
        if (i == 0) addr_a = a;
        else if (i == 1) addr_b = 8'(a);
        else addr_c = 6'(a);
    endtask

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0h expected %0h at t=%0t", name, i, act, exp, $time);
        end
    endtask

    // Reference model: read timing expressed as edge distance from acceptance
    logic [7:0] m_mem [NI][65536];
    bit         m_started [NI];
    bit         m_pend    [NI];
    int         m_rd_edge [NI];
    int         m_rd_addr [NI];
    bit         m_clearing[NI];
    int         m_clr_cnt [NI];
    logic [7:0] e_dout [NI];
    bit         e_valid[NI];
    bit         e_ack  [NI];
    bit         e_ready[NI];
    bit         e_err  [NI];
    int         edge_n = 0;

    task automatic model_step();
        edge_n++;
        for (int i = 0; i < NI; i++) begin
            int a;
            a = get_addr(i);
            e_valid[i] = 1'b0;
            e_ack[i]   = 1'b0;
            if (rst_v[i] === 1'b1) begin
                m_started[i]  = 1'b1;
                m_pend[i]     = 1'b0;
                e_err[i]      = 1'b0;
                e_dout[i]     = 8'h00;
                m_clearing[i] = clr_of(i);
                m_clr_cnt[i]  = 0;
                e_ready[i]    = !clr_of(i);
            end else if (m_clearing[i]) begin
                m_clr_cnt[i]++;
                if (m_clr_cnt[i] == depth_of(i)) begin
                    for (int j = 0; j < depth_of(i); j++) m_mem[i][j] = 8'h00;
                    m_clearing[i] = 1'b0;
                    e_ready[i]    = 1'b1;
                end
            end else if (m_pend[i]) begin
                if (edge_n - m_rd_edge[i] == lat_of(i)) begin
                    e_valid[i] = 1'b1;
                    e_dout[i]  = m_mem[i][m_rd_addr[i]];
                    m_pend[i]  = 1'b0;
                    e_ready[i] = 1'b1;
                end else if (rd_v[i] !== 1'b1) begin
                    m_pend[i]  = 1'b0;
                    e_ready[i] = 1'b1;
                end
            end else if (wr_v[i] === 1'b1) begin
                m_mem[i][a] = din_v[i];
                e_ack[i]    = 1'b1;
                if (rd_v[i] === 1'b1) e_err[i] = 1'b1;
            end else if (rd_v[i] === 1'b1) begin
                m_pend[i]    = 1'b1;
                m_rd_edge[i] = edge_n;
                m_rd_addr[i] = a;
                e_ready[i]   = 1'b0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            if (m_started[i]) begin
                check("model_valid", i, 32'(valid_v[i]), 32'(e_valid[i]));
                check("model_dout",  i, 32'(dout_v[i]),  32'(e_dout[i]));
                check("model_ack",   i, 32'(ack_v[i]),   32'(e_ack[i]));
                check("model_ready", i, 32'(ready_v[i]), 32'(e_ready[i]));
                check("model_err",   i, 32'(err_v[i]),   32'(e_err[i]));
            end
        end
    end

    task automatic wait_strobe(input int i, input int max_n, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (valid_v[i] !== 1'b1 && n < max_n);
        if (valid_v[i] !== 1'b1) check("strobe_timeout", i, 32'(0), 32'(1));
    endtask

    task automatic do_write(input int i, input logic [15:0] a, input logic [7:0] d);
        set_addr(i, a);
        din_v[i] = d;
        wr_v[i]  = 1'b1;
        @(negedge clk);
        wr_v[i]  = 1'b0;
    endtask

    task automatic do_read(input int i, input logic [15:0] a, input int exp_n,
                           input logic [7:0] d, input string name);
        int n;
        set_addr(i, a);
        rd_v[i] = 1'b1;
        wait_strobe(i, 40, n);
        check({name, "_lat"}, i, 32'(n), 32'(exp_n));
        check({name, "_data"}, i, 32'(dout_v[i]), 32'(d));
        rd_v[i] = 1'b0;
        @(negedge clk);
        check({name, "_width"}, i, 32'(valid_v[i]), 32'(0));
    endtask

    initial begin
        int n;
        int cnt;
        int prev;
        for (int i = 0; i < NI; i++) begin
            rst_v[i] = 1'b1;
            rd_v[i]  = 1'b0;
            wr_v[i]  = 1'b0;
            din_v[i] = 8'h00;
        end
        addr_a = '0;
        addr_b = '0;
        addr_c = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", 0, 32'(valid_v[0]), 32'(0));
        check("rst_dout",  0, 32'(dout_v[0]),  32'(0));
        check("rst_ready", 0, 32'(ready_v[0]), 32'(1));
        check("rst_err",   0, 32'(err_v[0]),   32'(0));
        check("rst_ready", 2, 32'(ready_v[2]), 32'(0));
        for (int i = 0; i < NI; i++) rst_v[i] = 1'b0;

        // Write then read, READ_LAT=3
        set_addr(0, 16'h1234);
        din_v[0] = 8'hA5;
        wr_v[0]  = 1'b1;
        @(negedge clk);
        wr_v[0] = 1'b0;
        check("wr_ack", 0, 32'(ack_v[0]), 32'(1));
        @(negedge clk);
        check("wr_ack_pulse", 0, 32'(ack_v[0]), 32'(0));
        do_read(0, 16'h1234, 4, 8'hA5, "rd_a5");

        // Block fill of 16 bytes with data equal to the low address byte
        wr_v[0] = 1'b1;
        for (int j = 0; j < 16; j++) begin
            set_addr(0, 16'h0100 + 16'(j));
            din_v[0] = 8'(j);
            @(negedge clk);
        end
        wr_v[0] = 1'b0;
        set_addr(0, 16'h0100);
        rd_v[0] = 1'b1;
        n = 0;
        cnt = 0;
        while (cnt < 16 && n < 200) begin
            @(negedge clk);
            n++;
            if (valid_v[0] === 1'b1) begin
                check("fill_data", 0, 32'(dout_v[0]), 32'(cnt));
                cnt++;
                if (cnt == 16) rd_v[0] = 1'b0;
                else set_addr(0, 16'h0100 + 16'(cnt));
            end
        end
        check("fill_count", 0, 32'(cnt), 32'(16));
        check("fill_cycles", 0, 32'(n), 32'(64));
        @(negedge clk);

        // Held write: three commits, three acks, last value wins
        set_addr(0, 16'h0300);
        wr_v[0] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            din_v[0] = 8'h10 + 8'(j);
            @(negedge clk);
            check("held_ack", 0, 32'(ack_v[0]), 32'(1));
        end
        wr_v[0] = 1'b0;
        @(negedge clk);
        check("held_ack_end", 0, 32'(ack_v[0]), 32'(0));
        do_read(0, 16'h0300, 4, 8'h12, "rd_held");

        // Abort during the wait phase
        do_write(0, 16'h0200, 8'h5A);
        rd_v[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rd_v[0] = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (valid_v[0] === 1'b1) cnt++;
        end
        check("abort_no_strobe", 0, 32'(cnt), 32'(0));

        // Full-latency read after abort; address moved after acceptance
        rd_v[0] = 1'b1;
        @(negedge clk);
        set_addr(0, 16'h1234);
        wait_strobe(0, 40, n);
        check("latched_lat", 0, 32'(n + 1), 32'(4));
        check("latched_data", 0, 32'(dout_v[0]), 32'(8'h5A));
        rd_v[0] = 1'b0;
        @(negedge clk);

        // Read accepted on the edge right after a write sees the new byte
        do_write(0, 16'h1234, 8'h77);
        do_read(0, 16'h1234, 4, 8'h77, "raw");

        // Read/write collision
        set_addr(0, 16'h0010);
        din_v[0] = 8'h3C;
        wr_v[0]  = 1'b1;
        rd_v[0]  = 1'b1;
        @(negedge clk);
        wr_v[0] = 1'b0;
        rd_v[0] = 1'b0;
        check("conflict_err", 0, 32'(err_v[0]), 32'(1));
        check("conflict_ack", 0, 32'(ack_v[0]), 32'(1));
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (valid_v[0] === 1'b1) cnt++;
        end
        check("conflict_no_strobe", 0, 32'(cnt), 32'(0));
        check("err_sticky", 0, 32'(err_v[0]), 32'(1));
        do_read(0, 16'h0010, 4, 8'h3C, "conflict_rd");
        rst_v[0] = 1'b1;
        @(negedge clk);
        rst_v[0] = 1'b0;
        check("err_cleared", 0, 32'(err_v[0]), 32'(0));
        check("ready_after_rst", 0, 32'(ready_v[0]), 32'(1));
        do_read(0, 16'h1234, 4, 8'h77, "retained");

        // READ_LAT=1: continuous handshake gives a strobe every second cycle
        wr_v[1] = 1'b1;
        for (int j = 0; j < 8; j++) begin
            set_addr(1, 16'(j));
            din_v[1] = 8'hF0 | 8'(j);
            @(negedge clk);
        end
        wr_v[1] = 1'b0;
        set_addr(1, 16'h0000);
        rd_v[1] = 1'b1;
        n = 0;
        cnt = 0;
        prev = 0;
        while (cnt < 8 && n < 100) begin
            @(negedge clk);
            n++;
            if (valid_v[1] === 1'b1) begin
                check("lat1_data", 1, 32'(dout_v[1]), 32'(8'hF0 | 8'(cnt)));
                check("lat1_spacing", 1, 32'(n - prev), 32'(2));
                prev = n;
                cnt++;
                if (cnt == 8) rd_v[1] = 1'b0;
                else set_addr(1, 16'(cnt));
            end
        end
        check("lat1_count", 1, 32'(cnt), 32'(8));
        @(negedge clk);
        do_write(1, 16'h00FF, 8'hEE);
        do_read(1, 16'h00FF, 2, 8'hEE, "lat1_top");

        // Clear-on-reset build
        n = 0;
        while (ready_v[2] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("init_clear_done", 2, 32'(ready_v[2]), 32'(1));
        do_write(2, 16'h0005, 8'h99);
        do_read(2, 16'h0005, 3, 8'h99, "clr_rd");
        set_addr(2, 16'h0005);
        rd_v[2] = 1'b1;
        @(negedge clk);
        check("clr_busy", 2, 32'(ready_v[2]), 32'(0));
        rst_v[2] = 1'b1;
        @(negedge clk);
        rst_v[2] = 1'b0;
        rd_v[2]  = 1'b0;
        set_addr(2, 16'h0007);
        din_v[2] = 8'hFF;
        wr_v[2]  = 1'b1;
        n = 0;
        cnt = 0;
        while (ready_v[2] !== 1'b1 && n < 200) begin
            if (valid_v[2] === 1'b1) cnt++;
            n++;
            @(negedge clk);
        end
        wr_v[2] = 1'b0;
        check("clear_ready_low", 2, 32'(n), 32'(64));
        check("reset_no_strobe", 2, 32'(cnt), 32'(0));
        do_read(2, 16'h0005, 3, 8'h00, "cleared5");
        do_read(2, 16'h003F, 3, 8'h00, "cleared63");
        do_read(2, 16'h0007, 3, 8'h00, "clear_ignores_wr");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

endmodule
